// File: rtl/mem_rmw_master.sv
// Single-outstanding memory master: word writes plus byte read-modify-write
// set/clear/pulse of one bit, with registered request outputs.
`ifndef MEM_RMW_DEFS
`define MEM_RMW_DEFS
`define ADDR_W 16
`define WORD_W 32
`define MEM_COUNT_W 3
`define MEM_COUNT_WORD 3'd4
`define MEM_COUNT_BYTE 3'd1
`define MEM_CODE_W 2
`endif

module mem_rmw_master #(
  parameter int unsigned OK_CODE   = 0,
  parameter int unsigned BIT_IDX_W = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_cmd_valid,
  output logic                    o_cmd_ready,
  input  logic [1:0]              i_cmd_op,
  input  logic [`ADDR_W-1:0]      i_cmd_addr,
  input  logic [`WORD_W-1:0]      i_cmd_data,
  input  logic [BIT_IDX_W-1:0]    i_cmd_bit,
  output logic [`ADDR_W-1:0]      o_req_addr,
  output logic [`WORD_W-1:0]      o_req_wr_data,
  output logic                    o_req_wr_en,
  output logic [`MEM_COUNT_W-1:0] o_req_count,
  input  logic [`WORD_W-1:0]      i_res_rd_data,
  input  logic [`MEM_CODE_W-1:0]  i_res_code,
  output logic                    o_done,
  output logic                    o_err,
  output logic [7:0]              o_rd_byte
);

  typedef enum logic [2:0] {IDLE, WR, WR_RSP, RD, RD_RSP, WB, WB_RSP, DONE} state_t;

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_SET   = 2'd1;
  localparam logic [1:0] OP_PULSE = 2'd3;
  localparam logic [`MEM_CODE_W-1:0] OK = `MEM_CODE_W'(OK_CODE);

  state_t                  state_q, state_d;
  logic [1:0]              op_q, op_d;
  logic [`ADDR_W-1:0]      addr_q, addr_d;
  logic [BIT_IDX_W-1:0]    bit_q, bit_d;
  logic                    clr_phase_q, clr_phase_d;
  logic [`ADDR_W-1:0]      req_addr_q, req_addr_d;
  logic [`WORD_W-1:0]      req_wr_data_q, req_wr_data_d;
  logic                    req_wr_en_q, req_wr_en_d;
  logic [`MEM_COUNT_W-1:0] req_count_q, req_count_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic [7:0]              rd_byte_q, rd_byte_d;

  logic       code_ok;
  logic       set_val;
  logic [7:0] mask;
  logic [7:0] wb_byte;
  logic       unused_rd_hi;

  // Only the addressed byte of the read word matters.
  assign unused_rd_hi = ^i_res_rd_data[`WORD_W-1:8];

  always_comb begin
    code_ok = (i_res_code == OK);
    mask    = 8'd1 << bit_q;
    // PULSE sets in its first half and clears in its second.
    set_val = (op_q == OP_SET) || ((op_q == OP_PULSE) && !clr_phase_q);
    wb_byte = set_val ? (i_res_rd_data[7:0] | mask) : (i_res_rd_data[7:0] & ~mask);

    state_d       = state_q;
    op_d          = op_q;
    addr_d        = addr_q;
    bit_d         = bit_q;
    clr_phase_d   = clr_phase_q;
    req_addr_d    = req_addr_q;
    req_wr_data_d = req_wr_data_q;
    req_wr_en_d   = 1'b0;
    req_count_d   = req_count_q;
    done_d        = 1'b0;
    err_d         = 1'b0;
    rd_byte_d     = rd_byte_q;

    // Request flops are loaded on the edge entering WR/RD/WB so the request
    // is visible during that state and answered in the following *_RSP state.
    case (state_q)
      IDLE: begin
        if (i_cmd_valid) begin
          op_d        = i_cmd_op;
          addr_d      = i_cmd_addr;
          bit_d       = i_cmd_bit;
          clr_phase_d = 1'b0;
          req_addr_d  = i_cmd_addr;
          if (i_cmd_op == OP_WRITE) begin
            state_d       = WR;
            req_wr_data_d = i_cmd_data;
            req_wr_en_d   = 1'b1;
            req_count_d   = `MEM_COUNT_WORD;
          end else begin
            state_d     = RD;
            req_count_d = `MEM_COUNT_BYTE;
          end
        end
      end
      WR: state_d = WR_RSP;
      WR_RSP: begin
        state_d = DONE;
        done_d  = 1'b1;
        err_d   = !code_ok;
      end
      RD: state_d = RD_RSP;
      RD_RSP: begin
        rd_byte_d = i_res_rd_data[7:0];
        if (!code_ok) begin
          state_d = DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          state_d       = WB;
          req_addr_d    = addr_q;
          req_wr_data_d = {{(`WORD_W-8){1'b0}}, wb_byte};
          req_wr_en_d   = 1'b1;
          req_count_d   = `MEM_COUNT_BYTE;
        end
      end
      WB: state_d = WB_RSP;
      WB_RSP: begin
        if (!code_ok) begin
          state_d = DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else if ((op_q == OP_PULSE) && !clr_phase_q) begin
          state_d     = RD;
          clr_phase_d = 1'b1;
          req_addr_d  = addr_q;
          req_count_d = `MEM_COUNT_BYTE;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      op_q          <= OP_WRITE;
      addr_q        <= '0;
      bit_q         <= '0;
      clr_phase_q   <= 1'b0;
      req_addr_q    <= '0;
      req_wr_data_q <= '0;
      req_wr_en_q   <= 1'b0;
      req_count_q   <= `MEM_COUNT_WORD;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      rd_byte_q     <= 8'h00;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      addr_q        <= addr_d;
      bit_q         <= bit_d;
      clr_phase_q   <= clr_phase_d;
      req_addr_q    <= req_addr_d;
      req_wr_data_q <= req_wr_data_d;
      req_wr_en_q   <= req_wr_en_d;
      req_count_q   <= req_count_d;
      done_q        <= done_d;
      err_q         <= err_d;
      rd_byte_q     <= rd_byte_d;
    end
  end

  assign o_cmd_ready   = (state_q == IDLE);
  assign o_req_addr    = req_addr_q;
  assign o_req_wr_data = req_wr_data_q;
  assign o_req_wr_en   = req_wr_en_q;
  assign o_req_count   = req_count_q;
  assign o_done        = done_q;
  assign o_err         = err_q;
  assign o_rd_byte     = rd_byte_q;

endmodule

// File: tb/tb_mem_rmw_master.sv
// Scoreboard bench for mem_rmw_master: directed commands against a byte
// memory responder; a monitor checks every write request and completion.
`ifndef MEM_RMW_DEFS
`define MEM_RMW_DEFS
`define ADDR_W 16
`define WORD_W 32
`define MEM_COUNT_W 3
`define MEM_COUNT_WORD 3'd4
`define MEM_COUNT_BYTE 3'd1
`define MEM_CODE_W 2
`endif

module tb_mem_rmw_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_cmd_valid = 1'b0;
  logic        o_cmd_ready;
  logic [1:0]  i_cmd_op = 2'd0;
  logic [15:0] i_cmd_addr = '0;
  logic [31:0] i_cmd_data = '0;
  logic [2:0]  i_cmd_bit = '0;
  logic [15:0] o_req_addr;
  logic [31:0] o_req_wr_data;
  logic        o_req_wr_en;
  logic [2:0]  o_req_count;
  logic [31:0] i_res_rd_data = '0;
  logic [1:0]  i_res_code = '0;
  logic        o_done;
  logic        o_err;
  logic [7:0]  o_rd_byte;

  mem_rmw_master #(.OK_CODE(0), .BIT_IDX_W(3)) dut (
    .clk(clk), .reset(reset),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_op(i_cmd_op), .i_cmd_addr(i_cmd_addr), .i_cmd_data(i_cmd_data), .i_cmd_bit(i_cmd_bit),
    .o_req_addr(o_req_addr), .o_req_wr_data(o_req_wr_data), .o_req_wr_en(o_req_wr_en),
    .o_req_count(o_req_count), .i_res_rd_data(i_res_rd_data), .i_res_code(i_res_code),
    .o_done(o_done), .o_err(o_err), .o_rd_byte(o_rd_byte)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct { logic [15:0] addr; logic [31:0] data; logic [2:0] count; } wr_t;
  typedef struct { logic err; logic chk_byte; logic [7:0] rd_byte; int lat; } done_t;

  wr_t   exp_wr[$];
  done_t exp_done[$];
  int    vectors = 0;
  int    miscompares = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail_event(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: got event/timeout, expected none", nm);
  endtask

  // Responder: a byte memory answering the request of the previous cycle.
  logic [7:0]  mem [logic [15:0]];
  logic        prev_wr = 1'b0;
  logic [15:0] prev_addr = '0;
  bit          bad_rd = 0;
  bit          bad_wr = 0;

  always @(negedge clk) begin
    if (prev_wr) begin
      i_res_code    = bad_wr ? 2'd1 : 2'd0;
      i_res_rd_data = 32'h0;
    end else begin
      i_res_code    = bad_rd ? 2'd1 : 2'd0;
      i_res_rd_data = {24'hABCDEF, (mem.exists(prev_addr) ? mem[prev_addr] : 8'h00)};
    end
    prev_wr   = o_req_wr_en;
    prev_addr = o_req_addr;
    if (o_req_wr_en) mem[o_req_addr] = o_req_wr_data[7:0];
  end

  // Monitor: checks writes and completions against the expectation queues.
  bit in_flight = 0;
  bit ready_bad = 0;
  int lat = 0;

  always @(negedge clk) begin
    wr_t   w;
    done_t d;
    if (in_flight) begin
      lat++;
      if (o_cmd_ready) ready_bad = 1;
    end
    if (o_req_wr_en) begin
      if (exp_wr.size() == 0) fail_event("unexpected_write");
      else begin
        w = exp_wr.pop_front();
        chk($sformatf("write@%0h", w.addr), {13'h0, o_req_addr, o_req_wr_data, o_req_count},
            {13'h0, w.addr, w.data, w.count});
      end
    end
    if (o_done) begin
      if (exp_done.size() == 0) fail_event("unexpected_done");
      else begin
        d = exp_done.pop_front();
        chk("err", {63'h0, o_err}, {63'h0, d.err});
        if (d.chk_byte) chk("rd_byte", {56'h0, o_rd_byte}, {56'h0, d.rd_byte});
        chk("latency", 64'(lat), 64'(d.lat));
        chk("ready_low_while_busy", {63'h0, ready_bad}, 64'h0);
      end
      in_flight = 0;
    end
    if (reset) in_flight = 0;
    else if (o_cmd_ready && i_cmd_valid) begin
      in_flight = 1;
      lat = 0;
      ready_bad = 0;
    end
  end

  task automatic push_wr(input logic [15:0] a, input logic [31:0] dt, input logic [2:0] c);
    wr_t w;
    w.addr = a; w.data = dt; w.count = c;
    exp_wr.push_back(w);
  endtask

  task automatic push_done(input logic e, input logic cb, input logic [7:0] b, input int l);
    done_t d;
    d.err = e; d.chk_byte = cb; d.rd_byte = b; d.lat = l;
    exp_done.push_back(d);
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [31:0] dt,
                       input logic [2:0] b, input bit hold);
    bit acc = 0;
    i_cmd_op = op; i_cmd_addr = a; i_cmd_data = dt; i_cmd_bit = b;
    i_cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      if (o_cmd_ready) acc = 1;
      @(posedge clk); #1;
    end
    if (!acc) fail_event("accept_timeout");
    if (!hold) i_cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      if (o_done) seen = 1;
    end
    if (!seen) fail_event("done_timeout");
  endtask

  initial begin
    bit seen;
    mem[16'h0000] = 8'h0C;
    mem[16'h0020] = 8'hFF;
    mem[16'h0030] = 8'hA5;
    mem[16'h0040] = 8'h10;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    chk("rst_ready",   {63'h0, o_cmd_ready}, 64'h1);
    chk("rst_addr",    {48'h0, o_req_addr}, 64'h0);
    chk("rst_wr_data", {32'h0, o_req_wr_data}, 64'h0);
    chk("rst_wr_en",   {63'h0, o_req_wr_en}, 64'h0);
    chk("rst_count",   {61'h0, o_req_count}, {61'h0, `MEM_COUNT_WORD});
    chk("rst_done",    {63'h0, o_done}, 64'h0);
    chk("rst_err",     {63'h0, o_err}, 64'h0);
    chk("rst_rd_byte", {56'h0, o_rd_byte}, 64'h0);

    // WRITE_WORD
    push_wr(16'h0004, 32'hDEADBEEF, `MEM_COUNT_WORD);
    push_done(1'b0, 1'b1, 8'h00, 3);
    issue(2'd0, 16'h0004, 32'hDEADBEEF, 3'd0, 0);
    wait_done();

    // SET_BIT bit 1 of 0x0C
    push_wr(16'h0000, 32'h0000000E, `MEM_COUNT_BYTE);
    push_done(1'b0, 1'b1, 8'h0C, 5);
    issue(2'd1, 16'h0000, 32'h0, 3'd1, 0);
    wait_done();

    // PULSE_BIT bit 1 of 0x00: set then clear, second read sees 0x02
    push_wr(16'h0010, 32'h00000002, `MEM_COUNT_BYTE);
    push_wr(16'h0010, 32'h00000000, `MEM_COUNT_BYTE);
    push_done(1'b0, 1'b1, 8'h02, 9);
    issue(2'd3, 16'h0010, 32'h0, 3'd1, 0);
    wait_done();

    // CLR_BIT with a bad read code: no write, error at cycle 3
    bad_rd = 1;
    push_done(1'b1, 1'b0, 8'h00, 3);
    issue(2'd2, 16'h0020, 32'h0, 3'd5, 0);
    wait_done();
    bad_rd = 0;

    // CLR_BIT bit 7 of 0xA5
    push_wr(16'h0030, 32'h00000025, `MEM_COUNT_BYTE);
    push_done(1'b0, 1'b1, 8'hA5, 5);
    issue(2'd2, 16'h0030, 32'h0, 3'd7, 0);
    wait_done();

    // SET_BIT bit 0 of 0x10 with a bad write code
    bad_wr = 1;
    push_wr(16'h0040, 32'h00000011, `MEM_COUNT_BYTE);
    push_done(1'b1, 1'b1, 8'h10, 5);
    issue(2'd1, 16'h0040, 32'h0, 3'd0, 0);
    wait_done();
    bad_wr = 0;

    // Reset while SET_BIT is in WB
    push_wr(16'h0008, 32'h00000008, `MEM_COUNT_BYTE);
    issue(2'd1, 16'h0008, 32'h0, 3'd3, 0);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (o_req_wr_en) seen = 1;
      else begin @(posedge clk); #1; end
    end
    if (!seen) fail_event("wb_timeout");
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_wr_en", {63'h0, o_req_wr_en}, 64'h0);
    chk("midrst_ready", {63'h0, o_cmd_ready}, 64'h1);
    chk("midrst_addr",  {48'h0, o_req_addr}, 64'h0);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (o_done) seen = 1;
    end
    chk("midrst_no_done", {63'h0, seen}, 64'h0);
    push_wr(16'h000C, 32'h12345678, `MEM_COUNT_WORD);
    push_done(1'b0, 1'b1, 8'h00, 3);
    issue(2'd0, 16'h000C, 32'h12345678, 3'd0, 0);
    wait_done();

    // Valid held across two commands; fields change mid-operation
    push_wr(16'h0050, 32'hCAFEF00D, `MEM_COUNT_WORD);
    push_done(1'b0, 1'b1, 8'h00, 3);
    push_wr(16'h0000, 32'h0000008E, `MEM_COUNT_BYTE);
    push_done(1'b0, 1'b1, 8'h0E, 5);
    issue(2'd0, 16'h0050, 32'hCAFEF00D, 3'd0, 1);
    i_cmd_op = 2'd1; i_cmd_addr = 16'h0000; i_cmd_data = 32'h0; i_cmd_bit = 3'd7;
    wait_done();
    chk("b2b_ready_in_done", {63'h0, o_cmd_ready}, 64'h0);
    @(posedge clk); #1;
    chk("b2b_ready_after_done", {63'h0, o_cmd_ready}, 64'h1);
    @(posedge clk); #1;
    chk("b2b_second_accepted", {63'h0, o_cmd_ready}, 64'h0);
    i_cmd_op = 2'd0; i_cmd_addr = 16'hFFFF; i_cmd_data = 32'h0; i_cmd_bit = 3'd0;
    i_cmd_valid = 1'b0;
    wait_done();

    repeat (4) @(posedge clk);
    #1;
    chk("wr_queue_empty",   64'(exp_wr.size()), 64'h0);
    chk("done_queue_empty", 64'(exp_done.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
